alu_iterative: RTL and testbench

- Parametrised, multi-cycle successor to the per-thread execute-stage ALU.
- Accepts one operation per valid/ready handshake:
  - ADD, SUB and CMP complete in one cycle.
  - MUL uses shift-add iteration; DIV and REM use restoring-division iteration.
- Outputs a registered result, NZP compare flags and a divide-by-zero flag.
- Sits between the per-thread register file and writeback; the core scheduler stalls the execute stage on in_ready/out_valid.

---
 rtl/alu_iterative.sv | 172 +++++++++++++++++
 tb/tb_alu_iterative.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// ============================================================================
// Module  : alu_iterative
// Brief   : Multi-cycle unsigned ALU: single-cycle ADD/SUB/CMP, shift-add MUL,
//           restoring DIV/REM, with NZP compare and divide-by-zero flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iterative #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        nzp,
    output logic              div0
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_DIV = 3'b011;
    localparam logic [2:0] c_OP_REM = 3'b100;
    localparam logic [2:0] c_OP_CMP = 3'b101;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic [2:0]        r_nzp;
    logic              r_div0;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;      // MUL: shifted multiplicand
    logic [DATA_W-1:0] r_b;      // MUL: shifted multiplier; DIV: divisor
    logic [DATA_W-1:0] r_acc;    // MUL: partial product; DIV: partial remainder
    logic [DATA_W-1:0] r_q;      // DIV: dividend bits shifting out, quotient in
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic [DATA_W-1:0] w_fast_result;
    logic [DATA_W-1:0] w_mul_acc;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_q_next;

    assign w_accept  = in_valid && r_in_ready;
    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_shift    = {r_acc, r_q[DATA_W-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_ge       = (w_shift >= {1'b0, r_b});
    assign w_rem_next = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_q_next   = {r_q[DATA_W-2:0], w_ge};

    // Results for everything that completes straight from IDLE, incl. rt==0.
    always_comb begin
        w_fast_result = '0;
        case (op)
            c_OP_ADD: w_fast_result = rs + rt;
            c_OP_SUB: w_fast_result = rs - rt;
            c_OP_CMP: w_fast_result = rs - rt;
            c_OP_DIV: w_fast_result = {DATA_W{1'b1}};
            c_OP_REM: w_fast_result = rs;
            default:  w_fast_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_nzp       <= 3'b000;
            r_div0      <= 1'b0;
            r_op        <= 3'b000;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_in_ready <= 1'b0;
                        if (op == c_OP_MUL) begin
                            r_a     <= rs;
                            r_b     <= rt;
                            r_acc   <= '0;
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= S_MUL;
                        end else if ((op == c_OP_DIV || op == c_OP_REM) && rt != '0) begin
                            r_b     <= rt;
                            r_q     <= rs;
                            r_acc   <= '0;
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= S_DIV;
                        end else begin
                            r_result    <= w_fast_result;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                            if (op == c_OP_CMP)
                                r_nzp <= {rs < rt, rs == rt, rs > rt};
                            if (op == c_OP_DIV || op == c_OP_REM)
                                r_div0 <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_result    <= w_mul_acc;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_result    <= (r_op == c_OP_REM) ? w_rem_next : w_q_next;
                        r_div0      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign nzp       = r_nzp;
    assign div0      = r_div0;

endmodule

`default_nettype wire

// File: tb/tb_alu_iterative.sv
// ============================================================================
// Module  : tb_alu_iterative
// Brief   : Randomised and directed bench for alu_iterative against an
//           arithmetic reference model of latency and held outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_iterative;

    localparam int DW   = 8;
    localparam int MASK = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic          out_valid;
    logic [DW-1:0] result;
    logic [2:0]    nzp;
    logic          div0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    alu_iterative #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .result    (result),
        .nzp       (nzp),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: latency countdown plus plain arithmetic results.
    int m_ready, m_ov, m_result, m_nzp, m_div0, m_count;
    int p_result, p_nzp, p_div0, p_set_nzp, p_set_div0;

    task automatic m_complete();
        m_ov     = 1;
        m_result = p_result;
        if (p_set_nzp != 0)  m_nzp  = p_nzp;
        if (p_set_div0 != 0) m_div0 = p_div0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_ready = 1; m_ov = 0; m_result = 0; m_nzp = 0; m_div0 = 0; m_count = 0;
        end else if (m_ov != 0) begin
            m_ov    = 0;
            m_ready = 1;
        end else if (m_ready == 0) begin
            m_count--;
            if (m_count == 0) m_complete();
        end else if (in_valid) begin
            int a, b;
            a = int'(rs);
            b = int'(rt);
            p_set_nzp  = (op == 3'd5) ? 1 : 0;
            p_set_div0 = (op == 3'd3 || op == 3'd4) ? 1 : 0;
            p_div0     = (b == 0) ? 1 : 0;
            p_nzp      = ((a < b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a > b) ? 1 : 0);
            case (op)
                3'd0:    p_result = (a + b) & MASK;
                3'd1:    p_result = (a - b) & MASK;
                3'd2:    p_result = (a * b) & MASK;
                3'd3:    p_result = (b == 0) ? MASK : a / b;
                3'd4:    p_result = (b == 0) ? a : a % b;
                3'd5:    p_result = (a - b) & MASK;
                default: p_result = 0;
            endcase
            m_ready = 0;
            m_count = (op == 3'd2 || ((op == 3'd3 || op == 3'd4) && b != 0)) ? DW : 0;
            if (m_count == 0) m_complete();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  int'(in_ready),  m_ready);
            chk("out_valid", int'(out_valid), m_ov);
            chk("result",    int'(result),    m_result);
            chk("nzp",       int'(nzp),       m_nzp);
            chk("div0",      int'(div0),      m_div0);
        end
    end

    task automatic wait_accept();
        int n;
        bit rdy;
        n = 0;
        rdy = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input bit noise, output int lat, output int res,
                        output int f_nzp, output int f_div0);
        op = o; rs = a; rt = b; in_valid = 1'b1;
        wait_accept();
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                op = 3'($urandom);
                rs = DW'($urandom);
                rt = DW'($urandom);
            end
        end
        in_valid = 1'b0;
        if (!out_valid) chk("done_timeout", 0, 1);
        res    = int'(result);
        f_nzp  = int'(nzp);
        f_div0 = int'(div0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, res, fn, fd;
        logic [DW-1:0] a, b;
        reset = 1'b1; in_valid = 1'b0; op = 3'd0; rs = '0; rt = '0;
        @(posedge clk);
        #1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_nzp", int'(nzp), 0);
        chk("rst_div0", int'(div0), 0);
        @(posedge clk);
        #1;

        send(3'd0, 8'd200, 8'd100, 0, lat, res, fn, fd);
        chk("add_res", res, 44);  chk("add_lat", lat, 1);
        send(3'd2, 8'd200, 8'd2, 1, lat, res, fn, fd);
        chk("mul_res", res, 144); chk("mul_lat", lat, 9);
        send(3'd3, 8'd200, 8'd7, 0, lat, res, fn, fd);
        chk("div_res", res, 28);  chk("div_lat", lat, 9); chk("div_div0", fd, 0);
        send(3'd4, 8'd200, 8'd7, 1, lat, res, fn, fd);
        chk("rem_res", res, 4);   chk("rem_lat", lat, 9);
        send(3'd3, 8'd5, 8'd0, 0, lat, res, fn, fd);
        chk("div0_res", res, 255); chk("div0_flag", fd, 1); chk("div0_lat", lat, 1);
        send(3'd4, 8'd5, 8'd0, 0, lat, res, fn, fd);
        chk("rem0_res", res, 5);  chk("rem0_flag", fd, 1);
        send(3'd5, 8'd3, 8'd9, 0, lat, res, fn, fd);
        chk("cmp_res", res, 250); chk("cmp_nzp", fn, 4);
        send(3'd0, 8'd1, 8'd1, 0, lat, res, fn, fd);
        chk("add_hold_res", res, 2); chk("add_hold_nzp", fn, 4); chk("add_hold_div0", fd, 1);
        send(3'd5, 8'd9, 8'd9, 0, lat, res, fn, fd);
        chk("cmp_eq_nzp", fn, 2);
        send(3'd6, 8'd9, 8'd4, 0, lat, res, fn, fd);
        chk("rsvd_res", res, 0);  chk("rsvd_lat", lat, 1);

        // Abandon a multiply by resetting four cycles after accept.
        op = 3'd2; rs = 8'd255; rt = 8'd255; in_valid = 1'b1;
        wait_accept();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_nzp", int'(nzp), 0);
        chk("mid_rst_div0", int'(div0), 0);
        for (int i = 0; i < 12; i++) begin
            chk("mid_rst_no_ov", int'(out_valid), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send(3'd2, 8'd255, 8'd255, 0, lat, res, fn, fd);
        chk("mul_ff_res", res, 1); chk("mul_ff_lat", lat, 9);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0: a = 8'd0;
                1: a = 8'd255;
                default: a = DW'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 8'd0;
                1: b = 8'd1;
                2: b = 8'd255;
                default: b = DW'($urandom);
            endcase
            send(3'($urandom), a, b, 1'($urandom_range(0, 1)), lat, res, fn, fd);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
